cae_sched: RTL and testbench

- Sequencing controller for the CAE compute core: 3 PE rows feeding one accumulate stage.
- Walks every output of a layer and issues window/weight/bias addresses to the row buffers. Drives core enable/layer, waits for the core's completion flags, then emits one result write per output.
- Sits between the layer-level host FSM (start/layer_sel/done) and the CAE core plus the output feature-map memory.

---
 rtl/cae_sched.sv | 119 +++++++++++
 tb/tb_cae_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cae_sched.sv
// cae_sched: walks every conv window / FC neuron of a layer, drives the CAE core
// and emits one result write per output.
module cae_sched #(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int N_FILT   = 4,
    parameter int FC_OUT   = 10,
    parameter int FC_LINES = 16,
    parameter int ADDR_W   = 12,
    parameter int SUM_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              layer_sel,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              cae_enable,
    output logic              cae_layer,
    output logic [ADDR_W-1:0] row_base,
    output logic [ADDR_W-1:0] col_base,
    output logic [ADDR_W-1:0] wt_addr,
    output logic [ADDR_W-1:0] bias_addr,
    input  logic              conv_comp,
    input  logic              fc_done,
    input  logic              fc_line_done,
    input  logic [SUM_W-1:0]  sum_in,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [SUM_W-1:0]  out_data
);
    localparam logic [ADDR_W-1:0] OW     = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] OHW    = ADDR_W'((IMG_H - 2) * (IMG_W - 2));
    localparam logic [ADDR_W-1:0] OX_MAX = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] OY_MAX = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] F_MAX  = ADDR_W'(N_FILT - 1);
    localparam logic [ADDR_W-1:0] N_MAX  = ADDR_W'(FC_OUT - 1);
    localparam logic [ADDR_W-1:0] FCL    = ADDR_W'(FC_LINES);
    localparam logic [ADDR_W-1:0] L_MAX  = ADDR_W'(FC_LINES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, NEXT} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ox, oy, f, n, l;
    logic [ADDR_W-1:0] conv_addr;
    logic              last, hit;

    // Addresses are pure functions of the counter registers, so they are
    // stable from LOAD onward and never depend combinationally on inputs.
    assign cae_enable = state == RUN;
    assign row_base   = cae_layer ? l : oy;
    assign col_base   = cae_layer ? '0 : ox;
    assign wt_addr    = cae_layer ? n * FCL + l : f;
    assign bias_addr  = cae_layer ? n : f;
    assign conv_addr  = f * OHW + oy * OW + ox;

    always_comb begin
        last    = cae_layer ? n == N_MAX : (ox == OX_MAX && oy == OY_MAX && f == F_MAX);
        hit     = cae_layer ? fc_done : conv_comp;
        state_n = (state != IDLE && abort) ? IDLE :
                  state == IDLE  ? (start ? LOAD : IDLE) :
                  state == LOAD  ? RUN :
                  state == RUN   ? (hit ? WRITE : RUN) :
                  state == WRITE ? NEXT :
                  (last ? IDLE : LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ox        <= '0;
            oy        <= '0;
            f         <= '0;
            n         <= '0;
            l         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cae_layer <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_n;
            done      <= state == NEXT && !abort && last;
            out_valid <= state_n == WRITE;
            if (state == IDLE && start) begin
                cae_layer <= layer_sel;
                busy      <= 1'b1;
                ox        <= '0;
                oy        <= '0;
                f         <= '0;
                n         <= '0;
                l         <= '0;
            end
            if (state != IDLE && state_n == IDLE)
                busy <= 1'b0;
            // fc_done takes priority over a coincident line completion
            if (state == RUN && !abort && cae_layer)
                l <= fc_done ? '0 : (fc_line_done && l != L_MAX) ? l + 1'b1 : l;
            if (state_n == WRITE) begin
                out_data <= sum_in;
                out_addr <= cae_layer ? n : conv_addr;
            end
            if (state == NEXT && !abort && !last) begin
                if (cae_layer)
                    n <= n + 1'b1;
                else begin
                    ox <= ox == OX_MAX ? '0 : ox + 1'b1;
                    if (ox == OX_MAX) begin
                        oy <= oy == OY_MAX ? '0 : oy + 1'b1;
                        if (oy == OY_MAX)
                            f <= f + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_cae_sched.sv
// tb_cae_sched: directed stimulus with a queue scoreboard checked by a write monitor.
module tb_cae_sched;
    localparam int ADDR_W = 12;
    localparam int SUM_W  = 32;

    logic              clk = 1'b0;
    logic              rst, start, layer_sel, abort;
    logic              conv_comp, fc_done, fc_line_done;
    logic [SUM_W-1:0]  sum_in;
    logic              busy, done, cae_enable, cae_layer, out_valid;
    logic [ADDR_W-1:0] row_base, col_base, wt_addr, bias_addr, out_addr;
    logic [SUM_W-1:0]  out_data;

    logic [ADDR_W+SUM_W-1:0] exp_q[$];
    logic [ADDR_W+SUM_W-1:0] exp_e;
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    cae_sched #(
        .IMG_W(4), .IMG_H(4), .N_FILT(2), .FC_OUT(2), .FC_LINES(3),
        .ADDR_W(ADDR_W), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .layer_sel(layer_sel), .abort(abort),
        .busy(busy), .done(done), .cae_enable(cae_enable), .cae_layer(cae_layer),
        .row_base(row_base), .col_base(col_base), .wt_addr(wt_addr), .bias_addr(bias_addr),
        .conv_comp(conv_comp), .fc_done(fc_done), .fc_line_done(fc_line_done), .sum_in(sum_in),
        .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%0h, required no write", out_addr, out_data);
            end else begin
                exp_e = exp_q.pop_front();
                chk("write_addr", 64'(out_addr), 64'(exp_e[ADDR_W+SUM_W-1:SUM_W]));
                chk("write_data", 64'(out_data), 64'(exp_e[SUM_W-1:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en();
        for (int t = 0; t < 40 && !cae_enable; t++) tick();
        chk("enable_wait", 64'(cae_enable), 1);
    endtask

    task automatic launch(input logic ls, input bit hold);
        start = 1'b1;
        layer_sel = ls;
        tick();
        if (!hold) start = 1'b0;
        chk("launch_busy", 64'(busy), 1);
        chk("launch_load_en", 64'(cae_enable), 0);
        tick();
        chk("launch_run_en", 64'(cae_enable), 1);
    endtask

    task automatic finish_layer(input int d0);
        repeat (4) tick();
        chk("done_once", 64'(done_cnt - d0), 1);
        chk("busy_after_done", 64'(busy), 0);
        chk("queue_drained", 64'(exp_q.size()), 0);
    endtask

    task automatic conv_one(input int k);
        wait_en();
        chk("conv_layer", 64'(cae_layer), 0);
        chk("conv_col", 64'(col_base), 64'(k % 2));
        chk("conv_row", 64'(row_base), 64'((k / 2) % 2));
        chk("conv_wt", 64'(wt_addr), 64'(k / 4));
        chk("conv_bias", 64'(bias_addr), 64'(k / 4));
        repeat (4) tick();
        chk("conv_en_hold", 64'(cae_enable), 1);
        conv_comp = 1'b1;
        sum_in = 32'h1000 + 32'(k * 17);
        exp_q.push_back({ADDR_W'(k), sum_in});
        tick();
        conv_comp = 1'b0;
        chk("conv_en_gap", 64'(cae_enable), 0);
    endtask

    task automatic run_conv(input bit hold);
        int d0;
        d0 = done_cnt;
        launch(1'b0, hold);
        for (int k = 0; k < 8; k++) begin
            if (hold && k == 3) layer_sel = 1'b1;
            if (hold && k == 7) begin
                start = 1'b0;
                layer_sel = 1'b0;
            end
            conv_one(k);
        end
        finish_layer(d0);
    endtask

    task automatic run_fc(input bit simul);
        int d0;
        d0 = done_cnt;
        launch(1'b1, 1'b0);
        for (int nn = 0; nn < 2; nn++) begin
            wait_en();
            chk("fc_layer", 64'(cae_layer), 1);
            chk("fc_bias", 64'(bias_addr), 64'(nn));
            chk("fc_col", 64'(col_base), 0);
            if (nn == 0) begin
                conv_comp = 1'b1;
                tick();
                conv_comp = 1'b0;
            end
            for (int ll = 0; ll < 3; ll++) begin
                chk("fc_wt", 64'(wt_addr), 64'(nn * 3 + ll));
                chk("fc_row", 64'(row_base), 64'(ll));
                if (!(simul && ll == 2)) begin
                    fc_line_done = 1'b1;
                    tick();
                    fc_line_done = 1'b0;
                end
            end
            if (!simul) chk("fc_wt_sat", 64'(wt_addr), 64'(nn * 3 + 2));
            fc_done = 1'b1;
            fc_line_done = simul;
            sum_in = 32'hF000_0000 + 32'(nn);
            exp_q.push_back({ADDR_W'(nn), sum_in});
            tick();
            fc_done = 1'b0;
            fc_line_done = 1'b0;
        end
        finish_layer(d0);
    endtask

    task automatic abort_test();
        int d0;
        d0 = done_cnt;
        launch(1'b0, 1'b0);
        repeat (2) tick();
        conv_comp = 1'b1;
        abort = 1'b1;
        sum_in = 32'hDEAD;
        tick();
        conv_comp = 1'b0;
        abort = 1'b0;
        chk("abort_en", 64'(cae_enable), 0);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_valid", 64'(out_valid), 0);
        repeat (3) tick();
        chk("abort_no_done", 64'(done_cnt - d0), 0);
        run_conv(1'b0);
    endtask

    task automatic reset_test();
        int d0;
        d0 = done_cnt;
        launch(1'b0, 1'b0);
        conv_one(0);
        wait_en();
        chk("pre_rst_col", 64'(col_base), 1);
        chk("pre_rst_busy", 64'(busy), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_ctrl", 64'({busy, done, cae_enable, cae_layer, out_valid}), 0);
        chk("arst_addr", 64'({row_base, col_base, wt_addr, bias_addr}), 0);
        chk("arst_out", 64'({out_addr, out_data}), 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("post_rst_busy", 64'(busy), 0);
        chk("post_rst_en", 64'(cae_enable), 0);
        chk("post_rst_done", 64'(done_cnt - d0), 0);
        chk("post_rst_queue", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {start, layer_sel, abort, conv_comp, fc_done, fc_line_done} = '0;
        sum_in = '0;
        #12;
        chk("rst_ctrl", 64'({busy, done, cae_enable, cae_layer, out_valid}), 0);
        chk("rst_addr", 64'({row_base, col_base, wt_addr, bias_addr}), 0);
        chk("rst_out", 64'({out_addr, out_data}), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_busy", 64'(busy), 0);
        run_conv(1'b0);
        run_conv(1'b1);
        abort_test();
        run_fc(1'b0);
        run_fc(1'b1);
        reset_test();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
